// File: rtl/board_merge_responder.sv
// board_merge_responder
//   Owns the 2x5 digit board (4 bits per cell) and serves merge requests from
//   the cursor/selection logic. For each accepted request it reads the
//   destination and source cells, writes (dst + src) mod 10 to the
//   destination and returns a response on a valid/ready handshake.
//
// Ports
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   num                      active columns per row (0 or >5 means 5)
//   init_valid, init_status  bulk load of the board image (IDLE only)
//   req_valid/req_ready      merge request handshake; req_dst, req_src are cell indices
//   rsp_valid/rsp_ready      response handshake; rsp_ok, rsp_value are the result
//   status                   registered board image, cell k at [4k+3:4k]
//   busy                     high whenever the controller is not IDLE
//   merges_done              saturating count of successful merges
module board_merge_responder #(
    parameter int CELLS = 10,
    parameter int COLS  = 5,
    parameter int W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           num,
    input  logic                 init_valid,
    input  logic [CELLS*W-1:0]   init_status,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [3:0]           req_dst,
    input  logic [3:0]           req_src,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_ok,
    output logic [W-1:0]         rsp_value,
    output logic [CELLS*W-1:0]   status,
    output logic                 busy,
    output logic [7:0]           merges_done
);

    typedef enum logic [2:0] {IDLE, FETCH, SUM, WRITE, RESP} state_t;

    state_t         state, state_nxt;
    logic [2:0]     num_eff;
    logic           req_acc;
    logic           req_ok;
    logic [3:0]     dst_p0, src_p0;
    logic [W-1:0]   a_p1, b_p1;
    logic [W-1:0]   sum_p2;

    function automatic logic [2:0] eff_num(input logic [2:0] n);
        return (n == 3'd0 || n > 3'(COLS)) ? 3'(COLS) : n;
    endfunction

    // An index is usable only inside the board and inside the active columns.
    function automatic logic idx_ok(input logic [3:0] idx, input logic [2:0] n);
        logic [3:0] col;
        col = (idx >= 4'(COLS)) ? idx - 4'(COLS) : idx;
        return (idx < 4'(CELLS)) && (col < {1'b0, n});
    endfunction

    function automatic logic [W-1:0] cell_at(input logic [CELLS*W-1:0] img,
                                             input logic [3:0] idx);
        logic [W-1:0] v;
        v = '0;
        for (int k = 0; k < CELLS; k++)
            if (idx == 4'(k)) v = img[k*W +: W];
        return v;
    endfunction

    // Operands may be 10..15 after a bulk load, so the raw sum reaches 30:
    // two conditional subtractions cover every case without a divider.
    function automatic logic [W-1:0] mod10_sum(input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (W+1)'(20)) s = s - (W+1)'(20);
        if (s >= (W+1)'(10)) s = s - (W+1)'(10);
        return W'(s);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    assign num_eff = eff_num(num);
    assign req_ok  = idx_ok(req_dst, num_eff) && idx_ok(req_src, num_eff);
    assign req_acc = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!init_valid && req_valid) state_nxt = req_ok ? FETCH : RESP;
            FETCH:   state_nxt = SUM;
            SUM:     state_nxt = WRITE;
            WRITE:   state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // init_valid steals the IDLE cycle, so it must also hold off requests.
    always_comb begin
        req_ready = (state == IDLE) && !init_valid;
        busy      = (state != IDLE);
        rsp_valid = (state == RESP);
    end

    // Stage p0: latch indices at accept; validity was already decided here.
    always_ff @(posedge clk) begin
        if (req_acc) begin
            dst_p0 <= req_dst;
            src_p0 <= req_src;
        end
        // Stage p1: operand fetch from the board.
        if (state == FETCH) begin
            a_p1 <= cell_at(status, dst_p0);
            b_p1 <= cell_at(status, src_p0);
        end
        // Stage p2: modular sum.
        if (state == SUM)
            sum_p2 <= mod10_sum(a_p1, b_p1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status      <= '0;
            rsp_ok      <= 1'b0;
            rsp_value   <= '0;
            merges_done <= 8'd0;
        end else begin
            case (state)
                IDLE: if (init_valid) status <= init_status;
                WRITE: begin
                    for (int k = 0; k < CELLS; k++)
                        if (dst_p0 == 4'(k)) status[k*W +: W] <= sum_p2;
                    rsp_ok      <= 1'b1;
                    rsp_value   <= sum_p2;
                    merges_done <= sat_inc(merges_done);
                end
                RESP: if (rsp_ready) begin
                    rsp_ok    <= 1'b0;
                    rsp_value <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_board_merge_responder.sv
module tb_board_merge_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  num;
    logic        init_valid;
    logic [39:0] init_status;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_dst;
    logic [3:0]  req_src;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_ok;
    logic [3:0]  rsp_value;
    logic [39:0] status;
    logic        busy;
    logic [7:0]  merges_done;

    int checks   = 0;
    int failures = 0;

    // Reference model: board as plain integers plus a merge counter.
    int cells[10];
    int merges;

    typedef struct {
        bit          ld;
        logic [39:0] img;
        logic [3:0]  d;
        logic [3:0]  s;
        logic [2:0]  n;
        logic        ok;
        logic [3:0]  val;
    } vec_t;

    vec_t tbl[13];

    always #5 clk = ~clk;

    board_merge_responder dut (
        .clk(clk), .rst_n(rst_n), .num(num),
        .init_valid(init_valid), .init_status(init_status),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dst(req_dst), .req_src(req_src),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_ok(rsp_ok), .rsp_value(rsp_value),
        .status(status), .busy(busy), .merges_done(merges_done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] model_img();
        logic [39:0] img;
        for (int k = 0; k < 10; k++) img[k*4 +: 4] = 4'(cells[k]);
        return img;
    endfunction

    function automatic bit vld(input int i, input int n);
        int e;
        e = (n == 0 || n > 5) ? 5 : n;
        return (i < 10) && ((i % 5) < e);
    endfunction

    task automatic load(input logic [39:0] img, input string name);
        init_status = img;
        init_valid  = 1'b1;
        @(posedge clk); #1;
        init_valid = 1'b0;
        for (int k = 0; k < 10; k++) cells[k] = int'(img[k*4 +: 4]);
        chk(name, status, img);
    endtask

    // inject: 0 none, 1 init_valid during SUM, 2 reset during SUM.
    // hold: cycles of rsp_ready=0 once the response is up.
    task automatic merge(input logic [3:0] d, input logic [3:0] s, input logic [2:0] n,
                         input int inject, input int hold, input bit has_exp,
                         input logic t_ok, input logic [3:0] t_val, input string name);
        bit         ok;
        int         val;
        int         lat;
        logic       e_ok;
        logic [3:0] e_val;
        ok  = vld(int'(d), int'(n)) && vld(int'(s), int'(n));
        val = 0;
        if (ok) val = (cells[d] + cells[s]) % 10;
        e_ok  = has_exp ? t_ok  : ok;
        e_val = has_exp ? t_val : 4'(val);

        req_dst = d; req_src = s; num = n;
        rsp_ready = (hold == 0);
        req_valid = 1'b1;
        #1;
        chk({name, ".req_ready"}, req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        num = 3'($urandom_range(0, 7));
        lat = 1;
        while (!rsp_valid && lat < 12) begin
            if (lat == 2 && inject == 1) begin
                init_status = 40'({$urandom(), $urandom()});
                init_valid  = 1'b1;
            end
            if (lat == 2 && inject == 2) begin
                rst_n = 1'b0;
                #1;
                chk({name, ".rst_status"}, status, 0);
                chk({name, ".rst_rsp_valid"}, rsp_valid, 0);
                chk({name, ".rst_merges"}, merges_done, 0);
                rst_n = 1'b1;
                for (int k = 0; k < 10; k++) cells[k] = 0;
                merges = 0;
                repeat (6) @(posedge clk);
                #1;
                chk({name, ".no_rsp"}, {rsp_valid, busy}, 0);
                return;
            end
            @(posedge clk); #1;
            init_valid = 1'b0;
            lat++;
        end
        chk({name, ".latency"}, lat, ok ? 4 : 1);
        if (ok) begin
            cells[d] = val;
            if (merges < 255) merges++;
        end
        chk({name, ".rsp_ok"}, rsp_ok, e_ok);
        chk({name, ".rsp_value"}, rsp_value, e_val);
        chk({name, ".status"}, status, model_img());
        chk({name, ".merges"}, merges_done, merges);
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_dst = 4'd0; req_src = 4'd0; num = 3'd5;
            @(posedge clk); #1;
            chk({name, ".hold"}, {rsp_valid, rsp_ok, rsp_value, req_ready, busy},
                {1'b1, e_ok, e_val, 1'b0, 1'b1});
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk({name, ".handshake"}, {rsp_valid, rsp_ok, rsp_value, busy, req_ready},
            {1'b0, 1'b0, 4'd0, 1'b0, 1'b1});
        chk({name, ".merges_after"}, merges_done, merges);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; num = 3'd5; init_valid = 1'b0; init_status = '0;
        req_valid = 1'b0; req_dst = '0; req_src = '0; rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) cells[k] = 0;
        merges = 0;

        #2 rst_n = 1'b0;
        #1;
        chk("reset.status", status, 0);
        chk("reset.rsp_valid", rsp_valid, 0);
        chk("reset.rsp_ok", rsp_ok, 0);
        chk("reset.rsp_value", rsp_value, 0);
        chk("reset.merges", merges_done, 0);
        chk("reset.busy", busy, 0);
        chk("reset.req_ready", req_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Board image A: cells 0..9 = 3,4,7,2,9,1,8,5,0,6
        // Board image B: cell0=15, cell1=15, cell3=12, cell4=9, rest 0
        tbl[0]  = '{1'b1, 40'h6058192743, 4'd0,  4'd6, 3'd5, 1'b1, 4'd1};
        tbl[1]  = '{1'b0, 40'h0,          4'd4,  4'd1, 3'd3, 1'b0, 4'd0};
        tbl[2]  = '{1'b0, 40'h0,          4'd12, 4'd1, 3'd3, 1'b0, 4'd0};
        tbl[3]  = '{1'b0, 40'h0,          4'd2,  4'd2, 3'd5, 1'b1, 4'd4};
        tbl[4]  = '{1'b0, 40'h0,          4'd1,  4'd0, 3'd0, 1'b1, 4'd5};
        tbl[5]  = '{1'b0, 40'h0,          4'd9,  4'd5, 3'd7, 1'b1, 4'd7};
        tbl[6]  = '{1'b0, 40'h0,          4'd7,  4'd8, 3'd3, 1'b0, 4'd0};
        tbl[7]  = '{1'b0, 40'h0,          4'd7,  4'd8, 3'd4, 1'b1, 4'd5};
        tbl[8]  = '{1'b0, 40'h0,          4'd10, 4'd0, 3'd5, 1'b0, 4'd0};
        tbl[9]  = '{1'b0, 40'h0,          4'd5,  4'd3, 3'd1, 1'b0, 4'd0};
        tbl[10] = '{1'b1, 40'h000009C0FF, 4'd0,  4'd1, 3'd5, 1'b1, 4'd0};
        tbl[11] = '{1'b0, 40'h0,          4'd3,  4'd4, 3'd5, 1'b1, 4'd1};
        tbl[12] = '{1'b0, 40'h0,          4'd1,  4'd1, 3'd5, 1'b1, 4'd0};

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].ld) load(tbl[i].img, $sformatf("vec%0d.load", i));
            merge(tbl[i].d, tbl[i].s, tbl[i].n, 0, 0, 1'b1, tbl[i].ok, tbl[i].val,
                  $sformatf("vec%0d", i));
        end

        // Response back-pressure: cell4 = 9 doubled -> 8, held for 5 cycles.
        merge(4'd4, 4'd4, 3'd5, 0, 5, 1'b1, 1'b1, 4'd8, "hold");

        // init_valid during SUM is ignored: cell3 = 1 + cell4 = 8 -> 9.
        merge(4'd3, 4'd4, 3'd5, 1, 0, 1'b1, 1'b1, 4'd9, "init_in_sum");

        // init_valid and req_valid together: load wins, request taken next cycle.
        req_dst = 4'd0; req_src = 4'd1; num = 3'd5; req_valid = 1'b1;
        init_status = 40'h0000000052; init_valid = 1'b1;
        #1;
        chk("same.req_ready", req_ready, 0);
        @(posedge clk); #1;
        init_valid = 1'b0;
        for (int k = 0; k < 10; k++) cells[k] = (k == 0) ? 2 : (k == 1) ? 5 : 0;
        chk("same.loaded", status, 40'h0000000052);
        chk("same.idle", busy, 0);
        merge(4'd0, 4'd1, 3'd5, 0, 0, 1'b1, 1'b1, 4'd7, "same.req");

        // Reset during SUM aborts the merge.
        merge(4'd0, 4'd1, 3'd5, 2, 0, 1'b0, 1'b0, 4'd0, "rst_mid");

        // Randomized merges against the model.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 7) == 0)
                load(40'({$urandom(), $urandom()}), "rand.load");
            merge(4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)),
                  3'($urandom_range(0, 7)), 0, $urandom_range(0, 2),
                  1'b0, 1'b0, 4'd0, "rand");
        end

        // Enough successful merges to pass the saturation point.
        load(40'h0000000031, "sat.load");
        for (int i = 0; i < 260; i++)
            merge(4'd0, 4'd1, 3'd5, 0, 0, 1'b0, 1'b0, 4'd0, "sat");
        chk("sat.final", merges_done, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/board_merge_responder.md
Name: board_merge_responder

Overview:
- Owns the 10-cell digit board (2 rows x 5 columns, 4 bits per cell) and serves merge requests from the cursor/selection logic.
- Per request it reads a destination cell and a source cell, computes (dst + src) mod 10, and writes the result back to the destination.
- It returns a response on a valid/ready handshake.
- The board image is exported flat for the display path. It can be bulk-loaded at game start.

Parameters:
- CELLS, 10, number of cells on the board; cell k occupies status[4k+3:4k].
- COLS, 5, cells per row; row 0 is cells 0-4, row 1 is cells 5-9.
- W, 4, bits per cell.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- num  input  3  active columns per row, legal 1..5; 0 or >5 is treated as 5.
- init_valid  input  1  bulk-load strobe for the board image.
- init_status  input  40  board image loaded when init_valid is accepted.
- req_valid  input  1  merge request valid.
- req_ready  output  1  merge request accepted when req_valid && req_ready at a rising edge.
- req_dst  input  4  destination cell index 0..9 (the first-selected cell).
- req_src  input  4  source cell index 0..9 (the second-selected cell).
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
- rsp_ok  output  1  1 = merge performed; 0 = request rejected.
- rsp_value  output  4  value written to the destination; 0 when rejected.
- status  output  40  current board image (registered).
- busy  output  1  high in every state except IDLE.
- merges_done  output  8  count of successful merges, saturates at 255.

Behaviour:
- Reset (async, rst_n=0):
  - status=0, state=IDLE, rsp_valid=0, rsp_ok=0, rsp_value=0, merges_done=0.
  - Reset mid-operation aborts the operation with no board write and no response.
- States: IDLE, FETCH, SUM, WRITE, RESP.
- req_ready = (state==IDLE) && !init_valid. It is combinational, and no other output has a combinational path from an input.
- IDLE:
  - If init_valid: status <= init_status, stay in IDLE. init_valid has priority over req_valid in the same cycle.
  - Else if req accepted: latch dst and src.
    - Index valid iff index < 10 and (index mod 5) < effective num.
    - Both valid -> FETCH. Either invalid -> RESP with rsp_ok=0, rsp_value=0, status untouched.
  - init_valid outside IDLE is ignored.
- FETCH: capture a = cell[dst], b = cell[src] into internal registers -> SUM.
- SUM:
  - sum = (a + b) mod 10, unsigned 5-bit addition (max 15+15=30) reduced by repeated subtraction of 10 or a compare chain; no divider.
  - Cells holding 10-15 (possible only via init) are still reduced mod 10.
  - -> WRITE.
- WRITE:
  - cell[dst] <= sum. Source cell and all other cells are unchanged.
  - rsp_ok <= 1, rsp_value <= sum, merges_done += 1 unless it is 255.
  - -> RESP.
- RESP:
  - rsp_valid=1; rsp_ok and rsp_value are held stable until the handshake.
  - On rsp_ready: rsp_valid <= 0, rsp_ok <= 0, rsp_value <= 0, -> IDLE.
  - rsp_ready while rsp_valid=0 is ignored.
- Timing: accept edge T; FETCH at T+1, SUM at T+2, WRITE at T+3; status is updated and rsp_valid=1 after edge T+3. A rejected request gives rsp_valid=1 after edge T.
- Throughput: the earliest next accept is the cycle after the response handshake edge.
- dst==src is legal: the cell is doubled mod 10 (7 -> 4).
- The board image of a successful merge is visible on status in the same cycle rsp_valid rises.
- num changing mid-operation has no effect: validity is decided only at accept.

Test Plan:
- Reset, init_status with cell0=3 and cell6=8, req dst=0 src=6, num=5, rsp_ready=1 -> rsp_valid 4 cycles after accept with rsp_ok=1, rsp_value=1; cell0=1, cell6=8, merges_done=1.
- num=3, req dst=4 src=1 -> rejected: rsp_ok=0 one cycle after accept, status unchanged, merges_done unchanged; repeat with dst=12 -> same result.
- cell2=7, req dst=2 src=2 -> cell2=4. With init cell0=15, cell1=15, req dst=0 src=1 -> cell0=0.
- Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_ok, rsp_value stable; req_ready=0 and busy=1 throughout; a second req_valid is not accepted until after the handshake.
- init_valid and req_valid in the same IDLE cycle -> board loaded, request not accepted (req_ready=0); request accepted next cycle. init_valid during SUM -> ignored.
- Assert rst_n=0 during SUM -> status=0, rsp_valid=0 immediately; after release no response appears. Perform 256 merges -> merges_done saturates at 255.
